key_event_sched: RTL and testbench

KEY_EVENT_SCHED -- requirements
Module: key_event_sched

---
 rtl/key_evt_pkg.sv | 30 +++
 rtl/key_debounce_fsm.sv | 217 +++++++++++++++++++++
 rtl/key_event_sched.sv | 155 +++++++++++++++
 tb/tb_key_event_sched.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_evt_pkg.sv
// -----------------------------------------------------------------------------
// key_evt_pkg
// Shared encodings for the key event scheduler:
//   - evt_type codes (press / release / long-press)
//   - per-key debounce FSM state encoding
//   - small elaboration-time helper for counter sizing
// Optional feature macro: KEY_LONG_PRESS_EN adds the LONG_HELD state.
// -----------------------------------------------------------------------------
package key_evt_pkg;

    localparam logic [1:0] EVT_PRESS   = 2'd0;
    localparam logic [1:0] EVT_RELEASE = 2'd1;
    localparam logic [1:0] EVT_LONG    = 2'd2;

    typedef enum logic [2:0] {
        ST_RELEASED     = 3'd0,
        ST_PRESS_WAIT   = 3'd1,
        ST_PRESSED      = 3'd2,
        ST_RELEASE_WAIT = 3'd3
`ifdef KEY_LONG_PRESS_EN
        ,
        ST_LONG_HELD    = 3'd4
`endif
    } key_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// -----------------------------------------------------------------------------
// key_debounce_fsm
// Debounce FSM, stable-tick counter and one-entry pending event slot for a
// single key.
// Optional feature macro: KEY_LONG_PRESS_EN (long-press detection).
// Ports:
//   clk, rst_n      clock, async active-low reset
//   i_pressed       synchronized key level, 1 = pressed
//   i_tick          one-cycle time tick
//   i_take          arbiter transfers this key's pending event this cycle
//   o_level         debounced key state, 1 = pressed
//   o_slot_valid    pending slot holds an event
//   o_slot_type     type of the pending event
//   o_drop          a new event is being lost to the full slot (combinational)
// -----------------------------------------------------------------------------
module key_debounce_fsm
    import key_evt_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 20,
`ifdef KEY_LONG_PRESS_EN
    parameter int LONG_TICKS     = 1000,
`endif
    parameter int CNT_W          = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_pressed,
    input  logic       i_tick,
    input  logic       i_take,
    output logic       o_level,
    output logic       o_slot_valid,
    output logic [1:0] o_slot_type,
    output logic       o_drop
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
`ifdef KEY_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
`endif

    key_state_e       r_state;
    key_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_post;
    logic [1:0]       w_post_type;
    logic             r_level;
    logic             r_slot_valid;
    logic [1:0]       r_slot_type;
`ifdef KEY_LONG_PRESS_EN
    // Remembers that RELEASE_WAIT was entered from LONG_HELD so a bounce
    // returns there and no second long-press is generated.
    logic             r_from_long;
    logic             w_from_long_nxt;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + 1'b1;
    endfunction

    function automatic logic is_down(input key_state_e s);
        case (s)
            ST_PRESSED, ST_RELEASE_WAIT: return 1'b1;
`ifdef KEY_LONG_PRESS_EN
            ST_LONG_HELD:                return 1'b1;
`endif
            default:                     return 1'b0;
        endcase
    endfunction

    // Next-state, counter and event-post logic of the debounce FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_post      = 1'b0;
        w_post_type = EVT_PRESS;
`ifdef KEY_LONG_PRESS_EN
        w_from_long_nxt = r_from_long;
`endif
        case (r_state)
            ST_RELEASED: begin
                if (i_pressed) begin
                    w_state_nxt = ST_PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = ST_RELEASED;
                end
            end
            ST_PRESS_WAIT: begin
                if (!i_pressed) begin
                    w_state_nxt = ST_RELEASED;
                    w_cnt_nxt   = '0;
                end else if (i_tick) begin
                    // This tick brings the stable count to DEBOUNCE_TICKS.
                    if (r_cnt == DEB_LAST) begin
                        w_state_nxt = ST_PRESSED;
                        w_cnt_nxt   = '0;
                        w_post      = 1'b1;
                        w_post_type = EVT_PRESS;
                    end else begin
                        w_cnt_nxt = sat_inc(r_cnt);
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            ST_PRESSED: begin
                if (!i_pressed) begin
                    w_state_nxt = ST_RELEASE_WAIT;
                    w_cnt_nxt   = '0;
`ifdef KEY_LONG_PRESS_EN
                    w_from_long_nxt = 1'b0;
`endif
                end
`ifdef KEY_LONG_PRESS_EN
                else if (i_tick) begin
                    if (r_cnt == LONG_LAST) begin
                        w_state_nxt = ST_LONG_HELD;
                        w_cnt_nxt   = '0;
                        w_post      = 1'b1;
                        w_post_type = EVT_LONG;
                    end else begin
                        w_cnt_nxt = sat_inc(r_cnt);
                    end
                end
`endif
                else begin
                    w_state_nxt = ST_PRESSED;
                end
            end
            ST_RELEASE_WAIT: begin
                if (i_pressed) begin
`ifdef KEY_LONG_PRESS_EN
                    w_state_nxt = r_from_long ? ST_LONG_HELD : ST_PRESSED;
`else
                    w_state_nxt = ST_PRESSED;
`endif
                    w_cnt_nxt   = '0;
                end else if (i_tick) begin
                    if (r_cnt == DEB_LAST) begin
                        w_state_nxt = ST_RELEASED;
                        w_cnt_nxt   = '0;
                        w_post      = 1'b1;
                        w_post_type = EVT_RELEASE;
                    end else begin
                        w_cnt_nxt = sat_inc(r_cnt);
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
`ifdef KEY_LONG_PRESS_EN
            ST_LONG_HELD: begin
                if (!i_pressed) begin
                    w_state_nxt     = ST_RELEASE_WAIT;
                    w_cnt_nxt       = '0;
                    w_from_long_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_LONG_HELD;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_RELEASED;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // FSM state, stable counter and debounced level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RELEASED;
            r_cnt   <= '0;
            r_level <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
            r_from_long <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= is_down(w_state_nxt);
`ifdef KEY_LONG_PRESS_EN
            r_from_long <= w_from_long_nxt;
`endif
        end
    end

    // A take in the same cycle frees the slot first, so a simultaneous post
    // refills it instead of being dropped.
    assign o_drop = w_post & r_slot_valid & ~i_take;

    // Pending event slot: keep-oldest on overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_valid <= 1'b0;
            r_slot_type  <= EVT_PRESS;
        end else if (w_post) begin
            if (r_slot_valid && !i_take) begin
                r_slot_valid <= r_slot_valid;
            end else begin
                r_slot_valid <= 1'b1;
                r_slot_type  <= w_post_type;
            end
        end else if (i_take) begin
            r_slot_valid <= 1'b0;
        end else begin
            r_slot_valid <= r_slot_valid;
        end
    end

    assign o_level      = r_level;
    assign o_slot_valid = r_slot_valid;
    assign o_slot_type  = r_slot_type;

endmodule

// File: rtl/key_event_sched.sv
// -----------------------------------------------------------------------------
// key_event_sched
// Debounces N_KEYS active-low raw buttons and schedules press / release
// (and optionally long-press) events onto a single valid/ready channel with
// round-robin arbitration between keys.
// Optional feature macro: KEY_LONG_PRESS_EN (long-press events, evt_type=2).
// Ports:
//   clk, rst_n   clock, async active-low reset
//   key_in       raw buttons, 0 = pressed
//   key_level    debounced state per key, 1 = pressed (registered)
//   evt_valid    event presented (registered)
//   evt_ready    consumer accepts the presented event
//   evt_key      key index of the presented event (registered)
//   evt_type     0 press, 1 release, 2 long-press (registered)
//   evt_drop     one-cycle pulse when an event was lost to a full slot
// -----------------------------------------------------------------------------
module key_event_sched
    import key_evt_pkg::*;
#(
    parameter int N_KEYS         = 4,
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 20,
    parameter int LONG_TICKS     = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_KEYS-1:0]         key_in,
    output logic [N_KEYS-1:0]         key_level,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [$clog2(N_KEYS)-1:0] evt_key,
    output logic [1:0]                evt_type,
    output logic                      evt_drop
);

    localparam int KW    = $clog2(N_KEYS);
    localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W = $clog2(max_int(DEBOUNCE_TICKS, LONG_TICKS) + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [KW-1:0] KEY_LAST  = KW'(N_KEYS - 1);

    logic [N_KEYS-1:0] r_sync1;
    logic [N_KEYS-1:0] r_sync2;
    logic [TW-1:0]     r_tick_cnt;
    logic              w_tick;
    logic [N_KEYS-1:0] w_level;
    logic [N_KEYS-1:0] w_slot_valid;
    logic [1:0]        w_slot_type [N_KEYS];
    logic [N_KEYS-1:0] w_drop;
    logic [N_KEYS-1:0] w_take;
    logic              w_found;
    logic [KW-1:0]     w_sel;
    logic              r_evt_valid;
    logic [KW-1:0]     r_evt_key;
    logic [1:0]        r_evt_type;
    logic              r_evt_drop;
    logic [KW-1:0]     r_rr_ptr;

    // Two-flop synchronizers, reset to the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_tick = (r_tick_cnt == TICK_LAST);

    // Shared time-tick divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        assign w_take[g] = r_evt_valid & evt_ready & (r_evt_key == KW'(g));

        key_debounce_fsm #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
`ifdef KEY_LONG_PRESS_EN
            .LONG_TICKS     (LONG_TICKS),
`endif
            .CNT_W          (CNT_W)
        ) u_fsm (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_pressed    (~r_sync2[g]),
            .i_tick       (w_tick),
            .i_take       (w_take[g]),
            .o_level      (w_level[g]),
            .o_slot_valid (w_slot_valid[g]),
            .o_slot_type  (w_slot_type[g]),
            .o_drop       (w_drop[g])
        );
    end

    // Round-robin search from r_rr_ptr; scanning offsets high-to-low lets the
    // lowest offset overwrite the others, so the nearest pending key wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            w_sel   = w_slot_valid[(int'(r_rr_ptr) + i) % N_KEYS]
                      ? KW'((int'(r_rr_ptr) + i) % N_KEYS) : w_sel;
            w_found = w_found | w_slot_valid[(int'(r_rr_ptr) + i) % N_KEYS];
        end
    end

    // Output channel: load a pending event while idle, hold it until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt_valid <= 1'b0;
            r_evt_key   <= '0;
            r_evt_type  <= EVT_PRESS;
            r_rr_ptr    <= '0;
        end else if (r_evt_valid) begin
            if (evt_ready) begin
                r_evt_valid <= 1'b0;
                r_rr_ptr    <= (r_evt_key == KEY_LAST) ? '0 : r_evt_key + 1'b1;
            end else begin
                r_evt_valid <= 1'b1;
            end
        end else if (w_found) begin
            r_evt_valid <= 1'b1;
            r_evt_key   <= w_sel;
            r_evt_type  <= w_slot_type[w_sel];
        end else begin
            r_evt_valid <= 1'b0;
        end
    end

    // Drop pulse, merged across keys.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt_drop <= 1'b0;
        end else begin
            r_evt_drop <= |w_drop;
        end
    end

    assign key_level = w_level;
    assign evt_valid = r_evt_valid;
    assign evt_key   = r_evt_key;
    assign evt_type  = r_evt_type;
    assign evt_drop  = r_evt_drop;

endmodule

// File: tb/tb_key_event_sched.sv
// -----------------------------------------------------------------------------
// tb_key_event_sched
// Table-driven vectors, hand-written corner sequences and randomized stimulus
// for key_event_sched, all checked against a reference model of the key rules
// (debounce runs measured in ticks, per-key pending slot, round-robin pick).
// Honours KEY_LONG_PRESS_EN for the long-press expectations.
// -----------------------------------------------------------------------------
module tb_key_event_sched;

    localparam int N   = 4;
    localparam int TD  = 4;
    localparam int DEB = 3;
    localparam int LNG = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] key_in;
    logic         evt_ready;
    logic [N-1:0] key_level;
    logic         evt_valid;
    logic [1:0]   evt_key;
    logic [1:0]   evt_type;
    logic         evt_drop;

    always #5 clk = ~clk;

    key_event_sched #(
        .N_KEYS         (N),
        .TICK_DIV       (TD),
        .DEBOUNCE_TICKS (DEB),
        .LONG_TICKS     (LNG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_level (key_level),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_key   (evt_key),
        .evt_type  (evt_type),
        .evt_drop  (evt_drop)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [N-1:0] m_s1, m_s2;          // raw input seen through two clock delays
    bit           m_lvl     [N];
    int           m_run     [N];       // edges spent disagreeing with m_lvl
    int           m_ticks   [N];       // ticks counted in that run
    bit           m_settled [N];
    int           m_lticks  [N];
    bit           m_long    [N];
    bit           m_sv      [N];
    logic [1:0]   m_st      [N];
    int           m_ptr, m_cyc, m_drops, dut_drops, exp_sel, n_xfer;
    int           n_type [4];
    bit           prev_valid, xfer_now;
    logic [1:0]   prev_key, prev_type;

    task automatic model_reset();
        m_s1 = '1;
        m_s2 = '1;
        for (int k = 0; k < N; k++) begin
            m_lvl[k] = 1'b0; m_run[k] = 0; m_ticks[k] = 0;
            m_settled[k] = 1'b0; m_lticks[k] = 0; m_long[k] = 1'b0;
            m_sv[k] = 1'b0; m_st[k] = 2'd0;
        end
        m_ptr      = 0;
        m_cyc      = 0;
        prev_valid = 1'b0;
    endtask

    task automatic model_post(input int k, input logic [1:0] t);
        if (m_sv[k]) begin
            m_drops++;
        end else begin
            m_sv[k] = 1'b1;
            m_st[k] = t;
        end
    endtask

    task automatic debounce(input int k, input bit tick);
        bit p;
        p = !m_s2[k];
        if (p != m_lvl[k]) begin
            m_settled[k] = 1'b0;
            m_lticks[k]  = 0;
            if (m_run[k] > 0 && tick) m_ticks[k]++;
            m_run[k]++;
            if (m_ticks[k] == DEB) begin
                m_lvl[k]     = p;
                m_run[k]     = 0;
                m_ticks[k]   = 0;
                m_settled[k] = p;
                m_long[k]    = 1'b0;
                model_post(k, p ? 2'd0 : 2'd1);
            end
        end else begin
            m_run[k]   = 0;
            m_ticks[k] = 0;
`ifdef KEY_LONG_PRESS_EN
            if (m_lvl[k] && !m_long[k]) begin
                if (m_settled[k] && tick) m_lticks[k]++;
                m_settled[k] = 1'b1;
                if (m_lticks[k] == LNG) begin
                    m_long[k] = 1'b1;
                    model_post(k, 2'd2);
                end
            end
`endif
        end
    endtask

    function automatic logic [N-1:0] model_level();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = m_lvl[k];
        return v;
    endfunction

    // One clock: advance the model with the pre-edge view, then compare.
    task automatic step();
        bit tick;
        tick     = (m_cyc % TD) == (TD - 1);
        xfer_now = evt_valid && evt_ready;
        if (xfer_now) begin
            chk("xfer_pending", 32'(m_sv[evt_key]), 32'd1);
            chk("xfer_type", 32'(evt_type), 32'(m_st[evt_key]));
            m_sv[evt_key] = 1'b0;
            m_ptr = (int'(evt_key) + 1) % N;
            n_xfer++;
            n_type[evt_type]++;
        end
        exp_sel = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (m_sv[(m_ptr + i) % N]) exp_sel = (m_ptr + i) % N;
        end
        for (int k = 0; k < N; k++) debounce(k, tick);
        m_s2 = m_s1;
        m_s1 = key_in;
        m_cyc++;
        prev_valid = evt_valid;
        prev_key   = evt_key;
        prev_type  = evt_type;
        @(posedge clk);
        #1;
        chk("key_level", 32'(key_level), 32'(model_level()));
        if (evt_drop) dut_drops++;
        if (evt_valid && (!prev_valid || xfer_now)) chk("rr_order", 32'(evt_key), 32'(exp_sel));
        if (prev_valid && !xfer_now) begin
            chk("hold_valid", 32'(evt_valid), 32'd1);
            chk("hold_key", 32'(evt_key), 32'(prev_key));
            chk("hold_type", 32'(evt_type), 32'(prev_type));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_key_level", 32'(key_level), 32'd0);
        chk("rst_evt_valid", 32'(evt_valid), 32'd0);
        chk("rst_evt_key", 32'(evt_key), 32'd0);
        chk("rst_evt_type", 32'(evt_type), 32'd0);
        chk("rst_evt_drop", 32'(evt_drop), 32'd0);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [N-1:0] keys;
        bit           ready;
        int           cycles;
        logic [N-1:0] exp_level;
        int           exp_xfers;
    } vec_t;

    vec_t vt [7];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0, d0, t0, t1, t2, exp_long;
        rst_n     = 1'b0;
        key_in    = '1;
        evt_ready = 1'b0;
        m_drops   = 0;
        dut_drops = 0;
        n_xfer    = 0;
        for (int i = 0; i < 4; i++) n_type[i] = 0;
        model_reset();

        // all four pressed while stalled, drain, release, glitch, single key
        vt[0] = '{4'b0000, 1'b0, 30, 4'b1111, 0};
        vt[1] = '{4'b0000, 1'b1, 12, 4'b1111, 4};
        vt[2] = '{4'b1111, 1'b1, 30, 4'b0000, 4};
        vt[3] = '{4'b1101, 1'b1,  6, 4'b0000, 0};
        vt[4] = '{4'b1111, 1'b1, 12, 4'b0000, 0};
        vt[5] = '{4'b1110, 1'b1, 24, 4'b0001, 1};
        vt[6] = '{4'b1111, 1'b1, 24, 4'b0000, 1};

        do_reset();
        for (int r = 0; r < 7; r++) begin
            key_in    = vt[r].keys;
            evt_ready = vt[r].ready;
            x0        = n_xfer;
            repeat (vt[r].cycles) step();
            chk($sformatf("row%0d_level", r), 32'(key_level), 32'(vt[r].exp_level));
            chk($sformatf("row%0d_xfers", r), 32'(n_xfer - x0), 32'(vt[r].exp_xfers));
        end

        // Key 2: press, release, press with the consumer stalled
        evt_ready = 1'b0;
        do_reset();
        d0 = dut_drops;
        key_in = 4'b1011; repeat (24) step();
        key_in = 4'b1111; repeat (24) step();
        key_in = 4'b1011; repeat (24) step();
        chk("drop_pulses", 32'(dut_drops - d0), 32'd2);
        chk("held_valid", 32'(evt_valid), 32'd1);
        chk("held_key", 32'(evt_key), 32'd2);
        chk("held_type", 32'(evt_type), 32'd0);
        evt_ready = 1'b1;
        x0 = n_xfer;
        repeat (4) step();
        chk("held_xfer", 32'(n_xfer - x0), 32'd1);
        key_in = 4'b1111; repeat (24) step();
        chk("drop_total_a", 32'(dut_drops), 32'(m_drops));

        // Key 3 held long, then released
        do_reset();
        evt_ready = 1'b1;
        t0 = n_type[0]; t1 = n_type[1]; t2 = n_type[2];
        key_in = 4'b0111; repeat (64) step();
`ifdef KEY_LONG_PRESS_EN
        exp_long = 1;
`else
        exp_long = 0;
`endif
        chk("long_press_cnt", 32'(n_type[0] - t0), 32'd1);
        chk("long_long_cnt", 32'(n_type[2] - t2), 32'(exp_long));
        key_in = 4'b1111; repeat (30) step();
        chk("long_release_cnt", 32'(n_type[1] - t1), 32'd1);
        chk("long_long_final", 32'(n_type[2] - t2), 32'(exp_long));

        // Reset while an event is presented, key kept held across reset
        do_reset();
        evt_ready = 1'b0;
        key_in = 4'b1110;
        for (int i = 0; i < 40 && !evt_valid; i++) step();
        chk("pre_reset_valid", 32'(evt_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(evt_valid), 32'd0);
        chk("async_rst_level", 32'(key_level), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_edge_valid", 32'(evt_valid), 32'd0);
        chk("rst_edge_key", 32'(evt_key), 32'd0);
        chk("rst_edge_type", 32'(evt_type), 32'd0);
        rst_n = 1'b1;
        model_reset();
        t0 = n_type[0];
        repeat (3) step();
        chk("post_rst_no_level", 32'(key_level), 32'd0);
        chk("post_rst_no_valid", 32'(evt_valid), 32'd0);
        evt_ready = 1'b1;
        repeat (20) step();
        chk("post_rst_level", 32'(key_level), 32'b0001);
        chk("post_rst_press", 32'(n_type[0] - t0), 32'd1);
        key_in = 4'b1111; repeat (24) step();

        // Randomized bursts against the model
        for (int b = 0; b < 40; b++) begin
            int len;
            key_in = N'($urandom);
            len    = $urandom_range(1, 30);
            for (int c = 0; c < len; c++) begin
                evt_ready = ($urandom_range(0, 3) != 0);
                step();
            end
        end
        key_in    = '1;
        evt_ready = 1'b1;
        repeat (60) step();
        chk("drain_empty", 32'(evt_valid), 32'd0);
        chk("drop_total", 32'(dut_drops), 32'(m_drops));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
